regfile_layer_cfg: RTL

Parametrised, double-buffered register bank for any accelerator layer (dense, conv, pool). It replaces the fixed per-layer register files.
- Host writes land in a shadow copy.
- Shadow is copied to the active copy (which drives the engine) only on an explicit commit while the engine is idle.
- Per-register access modes: RW, RO, W1C, PULSE.
- Reads are registered, with a valid strobe and an address-error flag.

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_cell.sv | 55 +++++
 rtl/regfile_layer_cfg.sv | 117 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the layer configuration register banks.
package regfile_pkg;

  typedef enum logic [1:0] {
    ACC_RW    = 2'd0,
    ACC_RO    = 2'd1,
    ACC_W1C   = 2'd2,
    ACC_PULSE = 2'd3
  } access_mode_e;

  typedef enum logic {
    CS_IDLE    = 1'b0,
    CS_PENDING = 1'b1
  } commit_state_e;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;
  localparam int MAX_REGS   = 64;

  localparam logic [13:0] LAYER_DENSE = 14'h400;
  localparam logic [13:0] LAYER_CONV  = 14'h800;
  localparam logic [13:0] LAYER_POOL  = 14'hC00;

  // The access map is passed zero-extended to MAX_REGS entries.
  function automatic access_mode_e mode_of(input logic [2*MAX_REGS-1:0] map, input int k);
    return access_mode_e'(map[2*k +: 2]);
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// One configuration register: shadow/active pair for RW, passthrough for RO,
// sticky bits for W1C and a single-cycle strobe for PULSE.
module regfile_cell
  import regfile_pkg::*;
#(
  parameter int           DATA_W    = DATA_W_DEF,
  parameter access_mode_e MODE      = ACC_RW,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              commit,
  input  logic [DATA_W-1:0] status,
  input  logic [DATA_W-1:0] event_bits,
  output logic [DATA_W-1:0] rd_value,
  output logic [DATA_W-1:0] cfg,
  output logic [DATA_W-1:0] pulse
);

  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] active;
  logic [DATA_W-1:0] w1c_q;
  logic [DATA_W-1:0] pulse_q;

  // Commit copies the pre-edge shadow, so a coincident write only reaches shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= RESET_VAL;
      active  <= RESET_VAL;
      w1c_q   <= '0;
      pulse_q <= '0;
    end else begin
      if (MODE == ACC_RW && wr)     shadow <= write_data;
      if (MODE == ACC_RW && commit) active <= shadow;
      if (MODE == ACC_W1C)          w1c_q  <= (w1c_q & ~(wr ? write_data : '0)) | event_bits;
      pulse_q <= (MODE == ACC_PULSE && wr) ? write_data : '0;
    end
  end

  always_comb begin
    rd_value = '0;
    cfg      = '0;
    case (MODE)
      ACC_RW:    begin rd_value = shadow; cfg = active; end
      ACC_RO:    begin rd_value = status; cfg = status; end
      ACC_W1C:   begin rd_value = w1c_q;  cfg = w1c_q;  end
      default:   begin rd_value = '0;     cfg = '0;     end
    endcase
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/regfile_layer_cfg.sv
// Double-buffered layer register bank: address decode, registered read path
// and the commit handshake that copies shadow to active while the engine is idle.
module regfile_layer_cfg
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_W-1:0]          BASE_ADDR  = ADDR_W'(LAYER_DENSE),
  parameter logic [2*NUM_REGS-1:0]      ACCESS_MAP = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          write_data,
  output logic [DATA_W-1:0]          read_data,
  output logic                       read_valid,
  output logic                       addr_err,
  output logic [NUM_REGS*DATA_W-1:0] cfg_out,
  input  logic [NUM_REGS*DATA_W-1:0] status_in,
  input  logic [NUM_REGS*DATA_W-1:0] event_in,
  output logic [NUM_REGS*DATA_W-1:0] pulse_out,
  input  logic                       commit_req,
  input  logic                       engine_busy,
  output logic                       commit_ack,
  output logic                       commit_pending
);

  localparam logic [2*MAX_REGS-1:0] MAP_EXT = (2*MAX_REGS)'(ACCESS_MAP);

  logic [NUM_REGS-1:0] match;
  logic [DATA_W-1:0]   rd_value [NUM_REGS];
  logic [DATA_W-1:0]   rd_data_p0;
  logic                hit;
  logic                copy;
  commit_state_e       state, state_nxt;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    localparam logic [ADDR_W:0] REG_ADDR = {1'b0, BASE_ADDR} + (ADDR_W+1)'(k + 1);

    assign match[k] = ({1'b0, addr} == REG_ADDR);

    regfile_cell #(
      .DATA_W    (DATA_W),
      .MODE      (mode_of(MAP_EXT, k)),
      .RESET_VAL (RESET_VALS[k*DATA_W +: DATA_W])
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr_en & match[k]),
      .write_data (write_data),
      .commit     (copy),
      .status     (status_in[k*DATA_W +: DATA_W]),
      .event_bits (event_in[k*DATA_W +: DATA_W]),
      .rd_value   (rd_value[k]),
      .cfg        (cfg_out[k*DATA_W +: DATA_W]),
      .pulse      (pulse_out[k*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    rd_data_p0 = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (match[k]) rd_data_p0 = rd_value[k];
  end

  assign hit = |match;

  // Stage p0 -> p1: read mux is registered; unmapped reads return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      read_valid <= rd_en;
      if (rd_en) read_data <= rd_data_p0;
      addr_err   <= (rd_en | wr_en) & ~hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CS_IDLE;
      commit_ack <= 1'b0;
    end else begin
      state      <= state_nxt;
      commit_ack <= copy;
    end
  end

  always_comb begin
    state_nxt = state;
    copy      = 1'b0;
    case (state)
      CS_IDLE:
        if (commit_req) begin
          if (engine_busy) state_nxt = CS_PENDING;
          else             copy      = 1'b1;
        end
      CS_PENDING:
        if (!engine_busy) begin
          copy      = 1'b1;
          state_nxt = CS_IDLE;
        end
      default: state_nxt = CS_IDLE;
    endcase
  end

  always_comb begin
    commit_pending = (state == CS_PENDING);
  end

endmodule
